// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter: FSM states and operation codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_ADD = 1'b1
  } op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundles the two requester handshakes, the response path and the ALU-side signals.
interface alu_arbiter_if #(
  parameter int bit_size = 15
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic              req0_op, req1_op;
  logic [bit_size:0] req0_a, req0_b, req1_a, req1_b;
  logic              resp0_valid, resp1_valid;
  logic              resp0_ready, resp1_ready;
  logic [bit_size:0] result;
  logic [bit_size:0] alu_a, alu_b, alu_out;
  logic              alu_and, alu_add;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b,
    input  resp0_ready, resp1_ready, alu_out,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output result, alu_a, alu_b, alu_and, alu_add
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b,
    output resp0_ready, resp1_ready, alu_out,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  result, alu_a, alu_b, alu_and, alu_add
  );
endinterface

// File: rtl/alu_arb_grant.sv
// Combinational grant between two requesters. ALU_ARB_RR_EN selects round-robin
// on a tie (loser of the previous grant wins); otherwise requester 0 has priority.
module alu_arb_grant (
`ifdef ALU_ARB_RR_EN
  input  logic last_i,
`endif
  input  logic valid0_i,
  input  logic valid1_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = valid0_i | valid1_i;
    gnt_id_o    = 1'b0;
    if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_RR_EN
      gnt_id_o = ~last_i;
`else
      gnt_id_o = 1'b0;
`endif
    end else begin
      gnt_id_o = valid1_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external AND/ADD ALU between two requesters: accept, drive ALU for one
// cycle, return the registered result. ALU_ARB_RR_EN enables round-robin tie-breaking.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int bit_size = 15
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [bit_size:0] a_q, b_q, result_q;
  logic              id_q;
  logic              gnt_valid, gnt_id, accept;

`ifdef ALU_ARB_RR_EN
  logic last_q;
`endif

  alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
    .last_i      (last_q),
`endif
    .valid0_i    (bus.req0_valid),
    .valid1_i    (bus.req1_valid),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Readys are held low while reset is asserted so nothing is accepted before IDLE.
  assign accept         = (state_q == IDLE) && gnt_valid && !rst;
  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept &&  gnt_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (id_q ? bus.resp1_ready : bus.resp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) result_q <= bus.alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      id_q <= gnt_id;
      op_q <= op_e'(gnt_id ? bus.req1_op : bus.req0_op);
      a_q  <= gnt_id ? bus.req1_a : bus.req0_a;
      b_q  <= gnt_id ? bus.req1_b : bus.req0_b;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= gnt_id;
  end
`endif

  // ALU inputs are decoded from registered state only; idle value is zero.
  assign bus.alu_a   = (state_q == EXEC) ? a_q : '0;
  assign bus.alu_b   = (state_q == EXEC) ? b_q : '0;
  assign bus.alu_and = (state_q == EXEC) && (op_q == OP_AND);
  assign bus.alu_add = (state_q == EXEC) && (op_q == OP_ADD);

  assign bus.resp0_valid = (state_q == RESP) && !id_q;
  assign bus.resp1_valid = (state_q == RESP) &&  id_q;
  assign bus.result      = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus random ops against a
// transaction-level model of grant policy and AND/ADD arithmetic.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   last_g = 1;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  alu_arbiter_if #(.bit_size(15)) bus ();

  alu_arbiter #(.bit_size(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // External ALU behaviour
  assign bus.alu_out = bus.alu_and ? (bus.alu_a & bus.alu_b) :
                       bus.alu_add ? (bus.alu_a + bus.alu_b) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic v0, input logic v1, input logic o0, input logic o1,
                       input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input int bp);
    int          w;
    logic        eo;
    logic [15:0] ea, eb, er;
    if (v0 && v1) w = RR ? ((last_g == 1) ? 0 : 1) : 0;
    else          w = v0 ? 0 : 1;
    eo = (w == 0) ? o0 : o1;
    ea = (w == 0) ? a0 : a1;
    eb = (w == 0) ? b0 : b1;
    er = eo ? 16'(ea + eb) : (ea & eb);

    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    #1;
    chk("ready0_accept", bus.req0_ready, (w == 0));
    chk("ready1_accept", bus.req1_ready, (w == 1));

    @(negedge clk);
    chk("alu_and", bus.alu_and, (eo == 1'b0));
    chk("alu_add", bus.alu_add, (eo == 1'b1));
    chk("alu_a", bus.alu_a, ea);
    chk("alu_b", bus.alu_b, eb);
    chk("readys_exec", {bus.req0_ready, bus.req1_ready}, 2'b00);

    @(negedge clk);
    chk("resp0_valid", bus.resp0_valid, (w == 0));
    chk("resp1_valid", bus.resp1_valid, (w == 1));
    chk("result", bus.result, er);

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_result", bus.result, er);
      chk("bp_resp_valid", {bus.resp1_valid, bus.resp0_valid}, (w == 0) ? 2'b01 : 2'b10);
      chk("bp_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end

    if (w == 0) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
    @(negedge clk);
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    chk("resp_cleared", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
    last_g = w;
  endtask

  initial begin
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    bus.req0_op = 1'b1; bus.req1_op = 1'b0;
    bus.req0_a = 16'h0; bus.req0_b = 16'h0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;

    // Reset state, with a request already pending
    repeat (2) @(negedge clk);
    chk("rst_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
    chk("rst_resp", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_alu_ctl", {bus.alu_and, bus.alu_add}, 2'b00);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 32'h0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(1, 0, 1'b1, 1'b0, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 0);
    do_op(0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hF0F0, 16'h0FF0, 0);
    do_op(0, 1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 0);

    // Both valid for four consecutive ops
    for (int i = 0; i < 4; i++)
      do_op(1, 1, 1'b1, 1'b0, 16'(i), 16'h0010, 16'hFFFF, 16'(i + 1), 0);

    // Response backpressure
    do_op(1, 0, 1'b1, 1'b0, 16'h1234, 16'h1111, 16'h0, 16'h0, 5);

    // Reset during EXEC
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    bus.req0_op = 1'b1; bus.req0_a = 16'h0005; bus.req0_b = 16'h0006;
    @(negedge clk);
    chk("pre_rst_exec", bus.alu_add, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_resp", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
    chk("midrst_result", bus.result, 16'h0000);
    chk("midrst_alu", {bus.alu_and, bus.alu_add, bus.alu_a, bus.alu_b}, 34'h0);
    chk("midrst_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    last_g = 1;
    @(negedge clk);
    chk("postrst_idle", {bus.resp0_valid, bus.resp1_valid, bus.req0_ready}, 3'b000);
    do_op(1, 0, 1'b1, 1'b0, 16'h0005, 16'h0006, 16'h0, 16'h0, 0);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      int m;
      m = $urandom_range(1, 3);
      do_op(m[0], m[1], 1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 2));
    end

    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing arbiter that shares the single `alu` datapath (AND / ADD, bit_size+1 wide) between two requesters, e.g. the fetch/address unit and the execute stage. It accepts one operation per grant through a valid/ready handshake, drives the ALU operands and one-hot control (`ALUand`/`ALUadd`), registers the result and returns it to the granting requester with a valid/ready response. The ALU is instantiated outside this block; this block owns its inputs and samples its output.

## Interface
- `bit_size`, 15: MSB index of data; data width is bit_size+1.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester N presents an operation.
- `req0_ready` / `req1_ready`  out  1  requester N's operation is accepted this cycle.
- `req0_op` / `req1_op`  in  1  0 = AND, 1 = ADD.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  bit_size+1  operands.
- `resp0_valid` / `resp1_valid`  out  1  result for requester N is on `result`.
- `resp0_ready` / `resp1_ready`  in  1  requester N consumes the result.
- `result`  out  bit_size+1  registered ALU result.
- `alu_a`, `alu_b`  out  bit_size+1  to ALU operands.
- `alu_and`, `alu_add`  out  1  to ALU control; never both 1.
- `alu_out`  in  bit_size+1  from ALU output.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant logic picks one requester with valid high and asserts only its ready.
  - On the handshake, latch op/a/b and the grant id, then go to EXEC.
  - `alu_and` = `alu_add` = 0.
- EXEC (exactly one cycle):
  - `alu_a`/`alu_b` = latched operands.
  - Op AND drives `alu_and`=1; op ADD drives `alu_add`=1.
  - `alu_out` is captured into `result` at the cycle end, then go to RESP.
- RESP:
  - Assert `respN_valid` for the granted id.
  - `result` is held stable until `respN_ready`; then go to IDLE.
  - No request is accepted while in EXEC or RESP; both readys are 0.
- Arithmetic: ADD wraps modulo 2^(bit_size+1) with no carry out. AND is bitwise.
- Simultaneous valid on both requesters: resolved by the grant policy (see Configuration). Only one ready is ever high.
- A requester may drop valid before ready without penalty. Operands must be held while valid=1 and ready=0.
- Reset mid-operation: return to IDLE; the in-flight op is discarded and no response is issued.

## Timing
- Reset values: all readys 0 until the first IDLE cycle after reset; resp*_valid 0; `result` 0; `alu_a`/`alu_b` 0; `alu_and`/`alu_add` 0; last-grant register = 1.
- Latency: accept at cycle N, ALU driven at N+1, `respN_valid` high at N+2.
- The earliest next accept is N+3 if the response is consumed at N+2. Maximum throughput is 1 op / 3 cycles.
- Readys are combinational from valids and state. The FSM itself has no combinational path from inputs to state.
- `alu_and`/`alu_add` are decoded from registered state only, so they are glitch-free relative to requests.

## Configuration
- `ALU_ARB_RR_EN` defined:
  - Round-robin grant. On a tie, the requester not granted last wins.
  - The last-grant register updates on every accept.
  - The reset value of 1 means requester 0 wins the first tie.
- Not defined: fixed priority; requester 0 always wins a tie. The last-grant register is absent.

## Structure
- Shared package `alu_pkg`:
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - op encoding OP_AND=1'b0, OP_ADD=1'b1.
- One sub-module, `alu_arb_grant`: combinational grant from valids and the last grant, with the `ALU_ARB_RR_EN` selection inside it.
- FSM, operand latches and result register live in `alu_arbiter`.

## Test plan
- Reset, then req0 ADD a=16'h0003 b=16'h0004 -> req0_ready at N, alu_add=1 at N+1, resp0_valid with result=16'h0007 at N+2.
- req1 AND a=16'hF0F0 b=16'h0FF0 -> alu_and=1 only, result=16'h00F0 on resp1.
- Wrap: ADD a=16'hFFFF b=16'h0002 -> result=16'h0001.
- Both valid for 4 consecutive ops:
  - with ALU_ARB_RR_EN, grants go 0,1,0,1;
  - without it, all four go to requester 0 while req0 stays valid.
- Backpressure: hold resp0_ready=0 for 5 cycles -> result stable, readys 0, no new accept; accept resumes in the cycle after ready.
- Assert rst during EXEC -> next cycle IDLE, no resp*_valid, outputs at reset values; the following request completes normally.
